// File: rtl/wide_compare_sequencer.sv
// Multi-word magnitude compare controller: walks two WORDS x S-bit operands
// MSB word first through an external S-bit comparator, stopping at the first unequal word.
module wide_compare_sequencer #(
    parameter int S     = 8,
    parameter int WORDS = 4,
    localparam int CW   = $clog2(WORDS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [S*WORDS-1:0]   in_a,
    input  logic [S*WORDS-1:0]   in_b,
    output logic [S-1:0]         cmp_a,
    output logic [S-1:0]         cmp_b,
    input  logic                 cmp_eq,
    input  logic                 cmp_gt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_eq,
    output logic                 out_gt,
    output logic [CW-1:0]        out_cycles,
    output logic                 err
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [S*WORDS-1:0]   a_reg;
    logic [S*WORDS-1:0]   b_reg;
    logic [IW-1:0]        idx;
    logic [CW-1:0]        count;

    // Comparator operands are a pure mux of registers, so they hold steady all cycle.
    assign cmp_a    = a_reg[int'(idx)*S +: S];
    assign cmp_b    = b_reg[int'(idx)*S +: S];
    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            idx        <= LAST_IDX;
            count      <= '0;
            out_eq     <= 1'b0;
            out_gt     <= 1'b0;
            out_cycles <= '0;
            out_valid  <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        idx   <= LAST_IDX;
                        count <= '0;
                        state <= CMP;
                    end
                end
                CMP: begin
                    count <= count + 1'b1;
                    // A contradictory comparator answer is flagged but still treated as equal.
                    if (cmp_eq && cmp_gt) begin
                        err <= 1'b1;
                    end
                    if (!cmp_eq) begin
                        out_eq     <= 1'b0;
                        out_gt     <= cmp_gt;
                        out_cycles <= count + 1'b1;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else if (idx == '0) begin
                        out_eq     <= 1'b1;
                        out_gt     <= 1'b0;
                        out_cycles <= count + 1'b1;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
